// File: rtl/prio_code_decoder_pkg.sv
// ---------------------------------------------------------------------------
// prio_dec_pkg : shared types and widths for the priority-code decoder
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prio_dec_pkg;

  localparam int CODE_W = 3;
  localparam int PAT_W  = 8;
  localparam int CNT_W  = 8;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_THERM  = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/prio_code_decoder_if.sv
// ---------------------------------------------------------------------------
// prio_code_decoder_if : code handshake and decoded-pattern bundle
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface prio_code_decoder_if;
  import prio_dec_pkg::*;

  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code;
  logic              mode;
  logic [PAT_W-1:0]  y;
  logic              y_valid;
  logic              busy;

  modport master (
    output en, in_valid, code, mode,
    input  in_ready, y, y_valid, busy
  );

  modport slave (
    input  en, in_valid, code, mode,
    output in_ready, y, y_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/prio_code_decoder_expand.sv
// ---------------------------------------------------------------------------
// prio_code_expand : combinational 3-bit code to one-hot/thermometer pattern
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prio_code_expand
  import prio_dec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              mode,
  output logic [PAT_W-1:0]  pattern
);

  // Thermometer fills every bit at or below the code, so the highest set bit
  // is the code in both modes.
  for (genvar i = 0; i < PAT_W; i++) begin : g_bit
    assign pattern[i] = (mode == MODE_THERM) ? (CODE_W'(i) <= code)
                                             : (CODE_W'(i) == code);
  end

endmodule

`default_nettype wire

// File: rtl/prio_code_decoder.sv
// ---------------------------------------------------------------------------
// prio_code_decoder : accepts a priority code and holds its expansion HOLD cycles
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prio_code_decoder
  import prio_dec_pkg::*;
#(
  parameter int HOLD = 4
) (
  input logic                clk,
  input logic                rst_n,
  prio_code_decoder_if.slave bus
);

  localparam logic [0:0]       ST_IDLE   = IDLE;
  localparam logic [0:0]       ST_DRIVE  = DRIVE;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [PAT_W-1:0] pattern;
  logic             last;
  logic             in_ready;
  logic             accept;

  prio_code_expand u_expand (
    .code    (bus.code),
    .mode    (bus.mode),
    .pattern (pattern)
  );

  assign last     = (cnt_q == HOLD_LAST);
  // Never depends on in_valid, so upstream may derive in_valid from in_ready.
  assign in_ready = bus.en && ((state_q == ST_IDLE) || last);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    if (accept) begin
      state_d   = ST_DRIVE;
      cnt_d     = '0;
      y_d       = pattern;
      y_valid_d = 1'b1;
    end else if (bus.en && (state_q == ST_DRIVE)) begin
      if (last) begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        y_d       = '0;
        y_valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.busy     = (state_q == ST_DRIVE);

endmodule

`default_nettype wire

// File: tb/tb_prio_code_decoder.sv
// ---------------------------------------------------------------------------
// tb_prio_code_decoder : randomized scoreboard bench, HOLD=4 and HOLD=1 instances
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prio_code_decoder;
  import prio_dec_pkg::*;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prio_code_decoder_if bus_a ();
  prio_code_decoder_if bus_b ();

  prio_code_decoder #(.HOLD(HOLD_A)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  prio_code_decoder #(.HOLD(HOLD_B)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic [7:0] y;
    logic [2:0] code;
  } exp_t;

  // One entry per cycle the pattern must still be shown.
  exp_t q_a[$];
  exp_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] ref_expand(logic [2:0] code, logic mode);
    logic [8:0] one = 9'd1;
    if (mode) return 8'((one << (code + 1)) - one);
    return 8'(one << code);
  endfunction

  function automatic logic [31:0] ref_penc(logic [7:0] v);
    logic [31:0] r = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) if (v[i]) r = 32'(i);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_a
    logic [7:0] ey;
    logic       ev;
    logic       acc;
    ev = (q_a.size() > 0);
    ey = ev ? q_a[0].y : 8'h00;
    chk("a_y", 32'(bus_a.y), 32'(ey));
    chk("a_y_valid", 32'(bus_a.y_valid), 32'(ev));
    chk("a_busy", 32'(bus_a.busy), 32'(ev));
    chk("a_in_ready", 32'(bus_a.in_ready), 32'(bus_a.en && q_a.size() <= 1));
    if (ev) chk("a_roundtrip", ref_penc(bus_a.y), 32'(q_a[0].code));
    acc = rst_n && bus_a.in_valid && bus_a.en && (q_a.size() <= 1);
    if (rst_n && bus_a.en && ev) void'(q_a.pop_front());
    if (acc) repeat (HOLD_A) q_a.push_back('{y: ref_expand(bus_a.code, bus_a.mode), code: bus_a.code});
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] ey;
    logic       ev;
    logic       acc;
    ev = (q_b.size() > 0);
    ey = ev ? q_b[0].y : 8'h00;
    chk("b_y", 32'(bus_b.y), 32'(ey));
    chk("b_y_valid", 32'(bus_b.y_valid), 32'(ev));
    chk("b_busy", 32'(bus_b.busy), 32'(ev));
    chk("b_in_ready", 32'(bus_b.in_ready), 32'(bus_b.en && q_b.size() <= 1));
    if (ev) chk("b_roundtrip", ref_penc(bus_b.y), 32'(q_b[0].code));
    acc = rst_n && bus_b.in_valid && bus_b.en && (q_b.size() <= 1);
    if (rst_n && bus_b.en && ev) void'(q_b.pop_front());
    if (acc) repeat (HOLD_B) q_b.push_back('{y: ref_expand(bus_b.code, bus_b.mode), code: bus_b.code});
  end

  task automatic drive(bit b, logic v, logic [2:0] c, logic m);
    if (b) begin
      bus_b.in_valid = v; bus_b.code = c; bus_b.mode = m;
    end else begin
      bus_a.in_valid = v; bus_a.code = c; bus_a.mode = m;
    end
  endtask

  task automatic set_en(bit b, logic v);
    if (b) bus_b.en = v;
    else   bus_a.en = v;
  endtask

  // Presents a code and returns 1ns after the edge that accepted it,
  // leaving in_valid high so a following send is back-to-back.
  task automatic send(bit b, logic [2:0] c, logic m, bit rnd_en);
    logic rdy;
    drive(b, 1'b1, c, m);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      rdy = b ? bus_b.in_ready : bus_a.in_ready;
      if (rdy) break;
      if (t > 200) begin
        chk("accept_wait", 32'(rdy), 32'd1);
        break;
      end
      @(posedge clk); #1;
      if (rnd_en) set_en(b, $urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(bit b, int n, bit rnd_en);
    drive(b, 1'b0, 3'd0, 1'b0);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_en) set_en(b, $urandom_range(0, 3) != 0);
    end
    set_en(b, 1'b1);
  endtask

  initial begin
    bus_a.en = 1'b1; bus_b.en = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_y", 32'(bus_a.y), 32'h00);
    chk("rst_y_valid", 32'(bus_a.y_valid), 32'd0);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // One-hot sweep, back-to-back.
    for (int c = 0; c < 8; c++) begin
      send(1'b0, 3'(c), MODE_ONEHOT, 1'b0);
      chk("sweep_y", 32'(bus_a.y), 32'(8'h01 << c));
    end
    idle(1'b0, 6, 1'b0);

    // Thermometer corners.
    send(1'b0, 3'd3, MODE_THERM, 1'b0); chk("therm3", 32'(bus_a.y), 32'h0F);
    send(1'b0, 3'd7, MODE_THERM, 1'b0); chk("therm7", 32'(bus_a.y), 32'hFF);
    send(1'b0, 3'd0, MODE_THERM, 1'b0); chk("therm0", 32'(bus_a.y), 32'h01);
    idle(1'b0, 6, 1'b0);

    // Round trip over all code/mode pairs (monitor checks re-encoding).
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 8; c++) send(1'b0, 3'(c), 1'(m), 1'b0);
    idle(1'b0, 6, 1'b0);

    // Stall at cnt = 1 for 5 cycles: pattern lasts HOLD+5 cycles.
    send(1'b0, 3'd6, MODE_ONEHOT, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    bus_a.en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_y", 32'(bus_a.y), 32'h40);
    chk("stall_ready", 32'(bus_a.in_ready), 32'd0);
    bus_a.en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("stall_tail_valid", 32'(bus_a.y_valid), 32'd1);
    @(posedge clk);
    #1 chk("stall_end_valid", 32'(bus_a.y_valid), 32'd0);
    idle(1'b0, 3, 1'b0);

    // HOLD = 1 streaming.
    send(1'b1, 3'd5, MODE_ONEHOT, 1'b0); chk("stream0", 32'(bus_b.y), 32'h20);
    send(1'b1, 3'd2, MODE_ONEHOT, 1'b0); chk("stream1", 32'(bus_b.y), 32'h04);
    send(1'b1, 3'd6, MODE_ONEHOT, 1'b0); chk("stream2", 32'(bus_b.y), 32'h40);
    drive(1'b1, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1 chk("stream_end", 32'(bus_b.y), 32'h00);

    // Randomized traffic with random enable stalls and gaps.
    for (int i = 0; i < 60; i++) begin
      send(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 2) != 0) idle(1'b0, $urandom_range(1, 3), 1'b1);
    end
    idle(1'b0, 8, 1'b0);
    for (int i = 0; i < 30; i++) begin
      send(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 2) == 0) idle(1'b1, $urandom_range(1, 2), 1'b1);
    end
    idle(1'b1, 4, 1'b0);

    // Asynchronous reset in the middle of a pattern.
    send(1'b0, 3'd5, MODE_THERM, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk("mid_rst_y", 32'(bus_a.y), 32'h00);
    chk("mid_rst_y_valid", 32'(bus_a.y_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus_a.busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus_a.in_ready), 32'd1);
    idle(1'b0, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prio_code_decoder.md
# prio_code_decoder

Sequential 3-to-8 decoder: the receiving end of the 8-to-3 priority-encoder interface. It accepts a 3-bit priority code over a valid/ready handshake and expands it into an 8-bit one-hot or thermometer pattern. The pattern is held on the output for a programmable number of cycles. It sits downstream of the priority encoder and drives select, strobe or indicator lines. Re-encoding its output with the priority encoder returns the original code in both modes.

## Interface
- HOLD, default 4, number of cycles each decoded pattern is driven; legal range 1..255
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low pauses the block
- in_valid  input  1  code present on code/mode
- in_ready  output  1  block can accept a code this cycle (combinational)
- code  input  3  priority code, 0..7
- mode  input  1  0 = one-hot, 1 = thermometer
- y  output  8  decoded pattern (registered)
- y_valid  output  1  y carries a live pattern (registered)
- busy  output  1  state is DRIVE (registered)

## Operation
- States:
  - IDLE: y = 0, y_valid = 0.
  - DRIVE: y holds the pattern; hold counter cnt (8 bit) counts 0..HOLD-1.
- in_ready = en && (state == IDLE || (state == DRIVE && cnt == HOLD-1)).
- Accept = in_valid && in_ready. code and mode are sampled only at accept.
- On accept:
  - y <= expand(code, mode); y_valid <= 1; cnt <= 0; state <= DRIVE.
- Expansion:
  - One-hot: y[code] = 1, all other bits 0.
  - Thermometer: y[i] = 1 for all i <= code. Code 0 gives 8'h01 and code 7 gives 8'hFF.
- DRIVE, en high, cnt < HOLD-1: cnt increments; y is unchanged.
- DRIVE, en high, cnt == HOLD-1:
  - With accept: load the new pattern (back-to-back, no gap).
  - Without accept: state <= IDLE, y <= 0, y_valid <= 0, cnt <= 0.
- en low, any state: in_ready = 0; cnt, y, y_valid and state are frozen. Resuming en continues from the frozen cnt.
- in_valid while in_ready = 0 is ignored. The upstream must hold code/mode stable until accepted.
- HOLD = 1: every DRIVE cycle is a final cycle, so in_ready stays high while en is high and a continuous stream is decoded one code per cycle.
- Reset (asserted at any time, including mid-DRIVE):
  - Immediately: state = IDLE, y = 8'h00, y_valid = 0, busy = 0, cnt = 0.
  - The pattern in flight is discarded.
  - After release, in_ready follows en.

## Timing
- Latency: accept at edge k puts y valid from after edge k through edge k+HOLD, i.e. exactly HOLD cycles.
- Back-to-back accepts produce consecutive patterns with no idle cycle. Throughput is one code per HOLD cycles.
- in_ready depends combinationally only on en, state and cnt, never on in_valid (no combinational loop).
- busy equals the DRIVE state; y_valid == busy at all times.

## Structure
- Package prio_dec_pkg holds:
  - state enum (IDLE, DRIVE)
  - mode constants MODE_ONEHOT = 1'b0, MODE_THERM = 1'b1
  - code and pattern width constants (3 and 8)
- The code-to-pattern function lives in a combinational sub-module, prio_code_expand (code, mode -> 8-bit pattern). The top instantiates it and registers its output at accept.
- The top holds the FSM, hold counter and handshake.

## Test plan
- Reset then idle: rst_n low mid-pattern -> y = 8'h00, y_valid = 0 and busy = 0 immediately (asynchronous); in_ready = 1 after release with en = 1.
- One-hot sweep, HOLD = 4: codes 0..7 with mode 0, each accepted when in_ready -> y = 8'h01, 8'h02 … 8'h80, each held exactly 4 cycles, with no gap between patterns.
- Thermometer: code 3, mode 1 -> y = 8'h0F for HOLD cycles; code 7 -> 8'hFF; code 0 -> 8'h01.
- Stall: en dropped for 5 cycles at cnt = 1 -> y frozen and in_ready = 0; the pattern ends HOLD+5 cycles after accept.
- HOLD = 1 streaming: in_valid held high with codes 5, 2, 6 -> y = 8'h20, 8'h04, 8'h40 on consecutive cycles, then y = 0 when in_valid drops.
- Round-trip: feed y into the priority encoder for all 16 code/mode pairs -> the encoder output equals the sent code.
